fifo_rd_packer: RTL and testbench

Read-side consumer of the async FIFO, running entirely in the FIFO read clock domain. It pops bytes from the FIFO read port and packs `PACK` consecutive bytes into one wide word. Each word is presented on a valid/ready output stream, with an optional idle-timeout flush for partial words. It sits directly downstream of the FIFO and feeds wide-datapath consumers.

---
 rtl/fifo_rd_packer.sv | 184 ++++++++++++++++++
 tb/tb_fifo_rd_packer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// ---------------------------------------------------------------------------
// fifo_rd_packer
//
// Read-side consumer of the async FIFO, living entirely in the FIFO read
// clock domain. Bytes are popped from the show-ahead FIFO read port and
// packed little-endian, PACK at a time, into one wide word. Each word is
// presented on a valid/ready stream. An optional idle timeout flushes a
// partially filled word.
//
// Build option:
//   FIFO_RD_PACKER_TIMEOUT_EN  - when defined, the idle timeout counter and
//                                partial-word flush are built in. When it is
//                                undefined, partial words wait for more
//                                bytes, and m_keep is all ones on every word.
//
// Parameters:
//   DATA_WIDTH - FIFO data width (byte lane width)
//   PACK       - lanes per output word, 2..8
//   TIMEOUT    - idle cycles before a partial word is flushed, 1..255
//
// Ports:
//   rclk    in   read clock, rising edge
//   rrst    in   asynchronous active-high reset
//   rdata   in   FIFO read data, valid whenever rempty is low
//   rempty  in   FIFO empty flag
//   rinc    out  FIFO pop strobe (combinational)
//   m_data  out  packed word (registered)
//   m_keep  out  lane-valid mask (registered)
//   m_valid out  output word valid (registered)
//   m_ready in   downstream accept
// ---------------------------------------------------------------------------
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                         rclk,
    input  logic                         rrst,
    input  logic [DATA_WIDTH-1:0]        rdata,
    input  logic                         rempty,
    output logic                         rinc,
    output logic [DATA_WIDTH*PACK-1:0]   m_data,
    output logic [PACK-1:0]              m_keep,
    output logic                         m_valid,
    input  logic                         m_ready
);

    localparam int                IDX_W    = $clog2(PACK);
    localparam int                ACC_W    = DATA_WIDTH * (PACK - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PACK - 1);

    // Stop elaboration on an out-of-range configuration.
    if (PACK < 2 || PACK > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("fifo_rd_packer: PACK must be 2..8 and TIMEOUT 1..255");
    end

    logic [ACC_W-1:0]            acc_q,   acc_d;
    logic [IDX_W-1:0]            idx_q,   idx_d;
    logic [DATA_WIDTH*PACK-1:0]  data_q,  data_d;
    logic [PACK-1:0]             keep_q,  keep_d;
    logic                        valid_q, valid_d;

    logic                        at_last;
    logic                        out_free;
    logic                        pop;
    logic                        flush;
    logic [DATA_WIDTH*PACK-1:0]  flush_data;
    logic [PACK-1:0]             flush_keep;

    // The last lane completes a word, so it may only be popped when the
    // output register is free or is being emptied this cycle.
    assign at_last  = (idx_q == LAST_IDX);
    assign out_free = !valid_q || m_ready;
    assign pop      = !rempty && (!at_last || out_free);
    assign rinc     = pop;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [7:0] tcnt_q, tcnt_d;

    // A pop always wins over a flush. The pop clears tcnt, so the flush
    // condition would no longer hold on the following cycle anyway.
    assign flush = !pop && (idx_q != '0) && (tcnt_q == TIMEOUT_CNT) && out_free;

    // Idle counter: it runs only while a partial word is waiting and
    // nothing is being popped. It restarts on any pop, whenever the
    // accumulator is empty, and when the partial word is flushed.
    always_comb begin
        tcnt_d = tcnt_q;
        if (pop || (idx_q == '0) || flush) begin
            tcnt_d = '0;
        end else if (tcnt_q != 8'hFF) begin
            tcnt_d = tcnt_q + 8'd1;
        end
    end

    // Build the partial word. Accumulator lanes at or above idx may hold
    // stale bytes from an earlier word, so they are forced to zero.
    always_comb begin
        flush_data = '0;
        flush_keep = '0;
        for (int i = 0; i < PACK - 1; i++) begin
            if (IDX_W'(i) < idx_q) begin
                flush_data[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i*DATA_WIDTH +: DATA_WIDTH];
                flush_keep[i] = 1'b1;
            end
        end
    end

    // Timeout counter register.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    assign flush      = 1'b0;
    assign flush_data = '0;
    assign flush_keep = '0;
`endif

    // Accumulator and output-register next state. A handshake frees the
    // register, and a load in the same cycle overwrites it with no bubble.
    // m_data and m_keep are only rewritten on a load or flush, so a word
    // that is not yet accepted stays stable.
    always_comb begin
        acc_d   = acc_q;
        idx_d   = idx_q;
        data_d  = data_q;
        keep_d  = keep_q;
        valid_d = valid_q;

        if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end

        if (pop) begin
            if (at_last) begin
                data_d  = {rdata, acc_q};
                keep_d  = '1;
                valid_d = 1'b1;
                idx_d   = '0;
            end else begin
                for (int i = 0; i < PACK - 1; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        acc_d[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
                    end
                end
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (flush) begin
            data_d  = flush_data;
            keep_d  = flush_keep;
            valid_d = 1'b1;
            idx_d   = '0;
        end
    end

    // State registers. Reset throws away both the partial bytes and any
    // word that has not been accepted.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            acc_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
        end
    end

    assign m_data  = data_q;
    assign m_keep  = keep_q;
    assign m_valid = valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_packer
//
// Self-checking bench for fifo_rd_packer with PACK=4 and TIMEOUT=16. It runs
// a table of per-cycle vectors for packing and backpressure, hand-written
// sequences for reset, the empty guard and the timeout behaviour (the
// timeout checks follow FIFO_RD_PACKER_TIMEOUT_EN), and a random run. In
// the random run every accepted word is checked against the ordered stream
// of pushed bytes.
// ---------------------------------------------------------------------------
module tb_fifo_rd_packer;

    localparam int DW      = 8;
    localparam int PACK    = 4;
    localparam int TIMEOUT = 16;

    logic                 rclk    = 1'b0;
    logic                 rrst    = 1'b1;
    logic [DW-1:0]        rdata   = '0;
    logic                 rempty  = 1'b1;
    logic                 rinc;
    logic [DW*PACK-1:0]   m_data;
    logic [PACK-1:0]      m_keep;
    logic                 m_valid;
    logic                 m_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          doReset;
        logic        empty;
        logic [7:0]  data;
        logic        ready;
        logic        expRinc;
        logic        expValid;
        logic [31:0] expData;
        logic [3:0]  expKeep;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] fifoQ[$];
    logic [7:0] expQ[$];
    int         pushedCount = 0;

    // Free-running read clock.
    always #5 rclk = ~rclk;

    fifo_rd_packer #(
        .DATA_WIDTH (DW),
        .PACK       (PACK),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [7:0] d, input logic r);
        rempty  = e;
        rdata   = d;
        m_ready = r;
        #1;
    endtask

    task automatic nextEdge();
        @(posedge rclk);
        #1;
    endtask

    task automatic resetDut();
        rrst    = 1'b1;
        rempty  = 1'b1;
        m_ready = 1'b0;
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        #1;
    endtask

    task automatic addVec(input bit rs, input logic e, input logic [7:0] d, input logic r,
                          input logic er, input logic ev, input logic [31:0] ed, input logic [3:0] ek);
        vec_t v;
        v.doReset  = rs;
        v.empty    = e;
        v.data     = d;
        v.ready    = r;
        v.expRinc  = er;
        v.expValid = ev;
        v.expData  = ed;
        v.expKeep  = ek;
        vecs.push_back(v);
    endtask

    // Compare one accepted word against the next bytes of the pushed stream.
    task automatic checkWord();
        int          k = 0;
        logic [31:0] exp = '0;
        for (int i = 0; i < PACK; i++) begin
            if (m_keep[i]) k++;
        end
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        checkOutput("keepNonzero", 64'(k > 0), 64'd1);
        checkOutput("keepShape", 64'(m_keep), 64'((1 << k) - 1));
`else
        checkOutput("keepFull", 64'(m_keep), 64'hF);
        k = PACK;
`endif
        if (expQ.size() < k) begin
            checkOutput("wordUnderflow", 64'(expQ.size()), 64'(k));
        end else begin
            for (int i = 0; i < k; i++) begin
                exp[i*8 +: 8] = expQ.pop_front();
            end
            checkOutput("wordData", 64'(m_data), 64'(exp));
        end
    endtask

    // One random-run cycle: optionally push a byte, drive the FIFO port
    // from the queue, check any handshake, then advance.
    task automatic randomCycle(input bit allowPush, input bit forceReady, inout int idleLeft);
        logic       popNow;
        logic [7:0] b;
        logic [7:0] d;
        if (allowPush) begin
            if (idleLeft > 0) begin
                idleLeft--;
            end else if ($urandom_range(0, 99) < 3) begin
                idleLeft = $urandom_range(5, 40);
            end else if ($urandom_range(0, 1) == 1) begin
                b = 8'($urandom);
                fifoQ.push_back(b);
                expQ.push_back(b);
                pushedCount++;
            end
        end
        if (fifoQ.size() == 0) d = 8'($urandom);
        else                   d = fifoQ[0];
        applyStimulus(fifoQ.size() == 0, d, forceReady || ($urandom_range(0, 3) != 0));
        if (rempty) checkOutput("rincWhenEmpty", 64'(rinc), 64'd0);
        if (m_valid && m_ready) checkWord();
        popNow = rinc;
        nextEdge();
        if (popNow && fifoQ.size() > 0) void'(fifoQ.pop_front());
    endtask

    initial begin
        int idle = 0;

        // Reset state while rrst is held.
        #12;
        checkOutput("rstValid", 64'(m_valid), 64'd0);
        checkOutput("rstData",  64'(m_data),  64'd0);
        checkOutput("rstKeep",  64'(m_keep),  64'd0);
        rempty = 1'b0; #1;
        checkOutput("rstRincNotEmpty", 64'(rinc), 64'd1);
        rempty = 1'b1; #1;
        checkOutput("rstRincEmpty", 64'(rinc), 64'd0);

        // Basic packing, m_ready held high.
        addVec(1, 0, 8'h11, 1, 1, 0, 32'h0, 4'h0);
        addVec(0, 0, 8'h22, 1, 1, 0, 32'h0, 4'h0);
        addVec(0, 0, 8'h33, 1, 1, 0, 32'h0, 4'h0);
        addVec(0, 0, 8'h44, 1, 1, 0, 32'h0, 4'h0);
        addVec(0, 1, 8'h00, 1, 0, 1, 32'h44332211, 4'hF);
        addVec(0, 1, 8'h00, 1, 0, 0, 32'h0, 4'h0);
        // Backpressure: 7 pops, then rinc holds low until m_ready rises.
        addVec(1, 0, 8'h11, 0, 1, 0, 32'h0, 4'h0);
        addVec(0, 0, 8'h22, 0, 1, 0, 32'h0, 4'h0);
        addVec(0, 0, 8'h33, 0, 1, 0, 32'h0, 4'h0);
        addVec(0, 0, 8'h44, 0, 1, 0, 32'h0, 4'h0);
        addVec(0, 0, 8'h55, 0, 1, 1, 32'h44332211, 4'hF);
        addVec(0, 0, 8'h66, 0, 1, 1, 32'h44332211, 4'hF);
        addVec(0, 0, 8'h77, 0, 1, 1, 32'h44332211, 4'hF);
        addVec(0, 0, 8'h88, 0, 0, 1, 32'h44332211, 4'hF);
        addVec(0, 0, 8'h88, 0, 0, 1, 32'h44332211, 4'hF);
        addVec(0, 0, 8'h88, 1, 1, 1, 32'h44332211, 4'hF);
        addVec(0, 1, 8'h00, 1, 0, 1, 32'h88776655, 4'hF);
        addVec(0, 1, 8'h00, 1, 0, 0, 32'h0, 4'h0);

        foreach (vecs[i]) begin
            if (vecs[i].doReset) resetDut();
            applyStimulus(vecs[i].empty, vecs[i].data, vecs[i].ready);
            checkOutput($sformatf("vec%0d_rinc", i), 64'(rinc), 64'(vecs[i].expRinc));
            checkOutput($sformatf("vec%0d_valid", i), 64'(m_valid), 64'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d_data", i), 64'(m_data), 64'(vecs[i].expData));
                checkOutput($sformatf("vec%0d_keep", i), 64'(m_keep), 64'(vecs[i].expKeep));
            end
            nextEdge();
        end

        // Empty guard: nothing pops and nothing appears.
        resetDut();
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1, 8'($urandom), 1'($urandom));
            checkOutput("guardRinc", 64'(rinc), 64'd0);
            checkOutput("guardValid", 64'(m_valid), 64'd0);
            nextEdge();
        end

        // Reset mid-word with a held word pending.
        resetDut();
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(0, 8'(i * 8'h11), 0);
            nextEdge();
        end
        applyStimulus(1, 8'h00, 0);
        checkOutput("preRstValid", 64'(m_valid), 64'd1);
        rrst = 1'b1; #1;
        checkOutput("midRstValid", 64'(m_valid), 64'd0);
        checkOutput("midRstData",  64'(m_data),  64'd0);
        checkOutput("midRstKeep",  64'(m_keep),  64'd0);
        rrst = 1'b0; #1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 8'(i), 1);
            nextEdge();
        end
        applyStimulus(1, 8'h00, 1);
        checkOutput("postRstValid", 64'(m_valid), 64'd1);
        checkOutput("postRstData",  64'(m_data),  64'h04030201);
        checkOutput("postRstKeep",  64'(m_keep),  64'hF);
        nextEdge();

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        // Timeout flush: the partial word appears 17 edges after the pop of B2.
        resetDut();
        applyStimulus(0, 8'hA1, 1);
        nextEdge();
        applyStimulus(0, 8'hB2, 1);
        nextEdge();
        applyStimulus(1, 8'h00, 1);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            nextEdge();
            checkOutput($sformatf("flushValid_e%0d", k), 64'(m_valid), 64'(k == TIMEOUT + 1));
        end
        checkOutput("flushData", 64'(m_data), 64'h0000B2A1);
        checkOutput("flushKeep", 64'(m_keep), 64'h3);
        nextEdge();
        checkOutput("flushValidDrop", 64'(m_valid), 64'd0);
`else
        // No timeout: a partial word waits for the rest of its bytes.
        resetDut();
        applyStimulus(0, 8'hA1, 1);
        nextEdge();
        applyStimulus(0, 8'hB2, 1);
        nextEdge();
        applyStimulus(1, 8'h00, 1);
        for (int k = 0; k < 100; k++) begin
            checkOutput("idleNoValid", 64'(m_valid), 64'd0);
            nextEdge();
        end
        applyStimulus(0, 8'hC3, 1);
        nextEdge();
        applyStimulus(0, 8'hD4, 1);
        nextEdge();
        applyStimulus(1, 8'h00, 1);
        checkOutput("resumeValid", 64'(m_valid), 64'd1);
        checkOutput("resumeData",  64'(m_data),  64'hD4C3B2A1);
        checkOutput("resumeKeep",  64'(m_keep),  64'hF);
        nextEdge();
`endif

        // Random traffic with idle gaps and random backpressure, then drain.
        resetDut();
        fifoQ.delete();
        expQ.delete();
        pushedCount = 0;
        for (int c = 0; c < 4000; c++) randomCycle(1'b1, 1'b0, idle);
        for (int c = 0; c < 300; c++)  randomCycle(1'b0, 1'b1, idle);
        checkOutput("fifoDrained", 64'(fifoQ.size()), 64'd0);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        checkOutput("leftoverBytes", 64'(expQ.size()), 64'd0);
`else
        checkOutput("leftoverBytes", 64'(expQ.size()), 64'(pushedCount % PACK));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
